// File: rtl/control_sequencer_pkg.sv
// ============================================================================
// control_sequencer_pkg : control-word bit indices, opcodes and FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

    localparam int MAX_STEPS = 5;
    localparam int CW_W      = 16;
    localparam int STEP_W    = 3;

    // Bit positions follow o_ctrl = {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}
    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    localparam logic [CW_W-1:0] M_HLT = CW_W'(1) << CW_HLT;
    localparam logic [CW_W-1:0] M_MI  = CW_W'(1) << CW_MI;
    localparam logic [CW_W-1:0] M_RI  = CW_W'(1) << CW_RI;
    localparam logic [CW_W-1:0] M_RO  = CW_W'(1) << CW_RO;
    localparam logic [CW_W-1:0] M_IO  = CW_W'(1) << CW_IO;
    localparam logic [CW_W-1:0] M_II  = CW_W'(1) << CW_II;
    localparam logic [CW_W-1:0] M_AI  = CW_W'(1) << CW_AI;
    localparam logic [CW_W-1:0] M_AO  = CW_W'(1) << CW_AO;
    localparam logic [CW_W-1:0] M_EO  = CW_W'(1) << CW_EO;
    localparam logic [CW_W-1:0] M_SU  = CW_W'(1) << CW_SU;
    localparam logic [CW_W-1:0] M_BI  = CW_W'(1) << CW_BI;
    localparam logic [CW_W-1:0] M_OI  = CW_W'(1) << CW_OI;
    localparam logic [CW_W-1:0] M_CE  = CW_W'(1) << CW_CE;
    localparam logic [CW_W-1:0] M_CO  = CW_W'(1) << CW_CO;
    localparam logic [CW_W-1:0] M_J   = CW_W'(1) << CW_J;
    localparam logic [CW_W-1:0] M_FI  = CW_W'(1) << CW_FI;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    // True when the opcode has at least one step after fetch.
    function automatic logic op_has_execute(input logic [3:0] op,
                                            input logic       flag_c,
                                            input logic       flag_z);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA,
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: return 1'b1;
            OP_JC:                          return flag_c;
            OP_JZ:                          return flag_z;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/microcode_rom.sv
// ============================================================================
// microcode_rom : combinational {opcode,step,C,Z} -> {control word, last step}
// Revision 1.0 -- FI bit only emitted when SEQ_COND_JUMP_EN is defined
// ============================================================================
`default_nettype none

module microcode_rom
    import control_sequencer_pkg::*;
(
    input  logic [3:0]        i_opcode,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_flag_c,
    input  logic              i_flag_z,
    output logic [CW_W-1:0]   o_ctrl,
    output logic              o_last_step
);

`ifdef SEQ_COND_JUMP_EN
    localparam logic [CW_W-1:0] FI_MASK = M_FI;
`else
    localparam logic [CW_W-1:0] FI_MASK = '0;
`endif

    always_comb begin
        o_ctrl      = '0;
        o_last_step = 1'b0;
        case (i_step)
            3'd0: o_ctrl = M_CO | M_MI;
            3'd1: begin
                // Empty instructions (and untaken jumps) end right after fetch.
                o_ctrl      = M_RO | M_II | M_CE;
                o_last_step = !op_has_execute(i_opcode, i_flag_c, i_flag_z);
            end
            3'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: o_ctrl = M_IO | M_MI;
                    OP_LDI: begin o_ctrl = M_IO | M_AI; o_last_step = 1'b1; end
                    OP_JMP: begin o_ctrl = M_IO | M_J;  o_last_step = 1'b1; end
                    OP_JC:  begin
                        o_ctrl      = i_flag_c ? (M_IO | M_J) : '0;
                        o_last_step = 1'b1;
                    end
                    OP_JZ:  begin
                        o_ctrl      = i_flag_z ? (M_IO | M_J) : '0;
                        o_last_step = 1'b1;
                    end
                    OP_OUT: begin o_ctrl = M_AO | M_OI; o_last_step = 1'b1; end
                    OP_HLT: begin o_ctrl = M_HLT;       o_last_step = 1'b1; end
                    default: o_last_step = 1'b1;
                endcase
            end
            3'd3: begin
                case (i_opcode)
                    OP_LDA: begin o_ctrl = M_RO | M_AI; o_last_step = 1'b1; end
                    OP_ADD, OP_SUB: o_ctrl = M_RO | M_BI;
                    OP_STA: begin o_ctrl = M_AO | M_RI; o_last_step = 1'b1; end
                    default: o_last_step = 1'b1;
                endcase
            end
            3'd4: begin
                o_last_step = 1'b1;
                case (i_opcode)
                    OP_ADD:  o_ctrl = M_EO | M_AI | FI_MASK;
                    OP_SUB:  o_ctrl = M_EO | M_AI | M_SU | FI_MASK;
                    default: o_ctrl = '0;
                endcase
            end
            default: o_last_step = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : T-state FSM, step counter and flags for the bus CPU
// Revision 1.0 -- conditional jumps and flag register under SEQ_COND_JUMP_EN
// ============================================================================
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic [3:0]        i_opcode,
    input  logic              i_alu_carry,
    input  logic              i_alu_zero,
    output logic [CW_W-1:0]   o_ctrl,
    output logic [STEP_W-1:0] o_tstate,
    output logic              o_halted
);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [CW_W-1:0]   rom_ctrl;
    logic              rom_last;
    logic              flag_c;
    logic              flag_z;

    microcode_rom u_rom (
        .i_opcode    (i_opcode),
        .i_step      (step_q),
        .i_flag_c    (flag_c),
        .i_flag_z    (flag_z),
        .o_ctrl      (rom_ctrl),
        .o_last_step (rom_last)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RESET;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        o_ctrl   = '0;
        o_tstate = '0;
        o_halted = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_RUN;
                step_d  = '0;
            end
            ST_RUN: begin
                o_ctrl   = rom_ctrl;
                o_tstate = step_q;
                if (rom_ctrl[CW_HLT]) begin
                    state_d = ST_HALTED;
                    step_d  = '0;
                end else if (rom_last || step_q == STEP_W'(MAX_STEPS - 1)) begin
                    // i_run is only honoured on the instruction boundary.
                    step_d = '0;
                    if (!i_run) begin
                        state_d = ST_PAUSE;
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_PAUSE: begin
                step_d = '0;
                if (i_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                o_ctrl   = M_HLT;
                o_tstate = STEP_W'(2);
                o_halted = 1'b1;
            end
            default: begin
                state_d = ST_RESET;
                step_d  = '0;
            end
        endcase
    end

`ifdef SEQ_COND_JUMP_EN
    logic [1:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (state_q == ST_RUN && rom_ctrl[CW_FI]) begin
            flags_d = {i_alu_carry, i_alu_zero};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            flags_q <= 2'b00;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_c = flags_q[1];
    assign flag_z = flags_q[0];
`else
    logic unused_alu_flags;

    assign flag_c           = 1'b0;
    assign flag_z           = 1'b0;
    assign unused_alu_flags = i_alu_carry ^ i_alu_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer : random-program bench with an instruction-level model
// Revision 1.0 -- follows SEQ_COND_JUMP_EN the same way as the design
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    localparam logic [15:0] W_HLT = 16'h8000, W_MI = 16'h4000, W_RI = 16'h2000, W_RO = 16'h1000;
    localparam logic [15:0] W_IO  = 16'h0800, W_II = 16'h0400, W_AI = 16'h0200, W_AO = 16'h0100;
    localparam logic [15:0] W_EO  = 16'h0080, W_SU = 16'h0040, W_BI = 16'h0020, W_OI = 16'h0010;
    localparam logic [15:0] W_CE  = 16'h0008, W_CO = 16'h0004, W_J  = 16'h0002, W_FI = 16'h0001;

`ifdef SEQ_COND_JUMP_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  opcode;
    logic        carry;
    logic        zero;
    logic [15:0] ctrl;
    logic [2:0]  tstate;
    logic        halted;

    int errors = 0;
    int checks = 0;
    bit mc, mz;
    logic [15:0] exp_q[$];

    control_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_run       (run),
        .i_opcode    (opcode),
        .i_alu_carry (carry),
        .i_alu_zero  (zero),
        .o_ctrl      (ctrl),
        .o_tstate    (tstate),
        .o_halted    (halted)
    );

    always #5 clk = ~clk;

    // Instruction-level model: full list of control words for one instruction.
    function automatic void build_expected(input logic [3:0] op);
        logic [15:0] fi;
        fi = COND_EN ? W_FI : 16'h0000;
        exp_q = {};
        exp_q.push_back(W_CO | W_MI);
        exp_q.push_back(W_RO | W_II | W_CE);
        case (op)
            4'h1: begin exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_RO | W_AI); end
            4'h2: begin exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_RO | W_BI);
                        exp_q.push_back(W_EO | W_AI | fi); end
            4'h3: begin exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_RO | W_BI);
                        exp_q.push_back(W_EO | W_AI | W_SU | fi); end
            4'h4: begin exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_AO | W_RI); end
            4'h5: exp_q.push_back(W_IO | W_AI);
            4'h6: exp_q.push_back(W_IO | W_J);
            4'h7: if (COND_EN && mc) exp_q.push_back(W_IO | W_J);
            4'h8: if (COND_EN && mz) exp_q.push_back(W_IO | W_J);
            4'hE: exp_q.push_back(W_AO | W_OI);
            4'hF: exp_q.push_back(W_HLT);
            default: ;
        endcase
    endfunction

    // Entered 1 time unit after the edge that starts T0 of the instruction.
    task automatic run_instr(input string tag, input logic [3:0] op, input bit c, input bit z);
        build_expected(op);
        for (int k = 0; k < exp_q.size(); k++) begin
            opcode = op; carry = c; zero = z;
            #1;
            checks++;
            if (ctrl !== exp_q[k] || tstate !== 3'(k) || (exp_q[k] != W_HLT && halted !== 1'b0)) begin
                errors++;
                $display("FAIL %s op=%h step %0d: ctrl=%h tstate=%0d halted=%b, required ctrl=%h tstate=%0d",
                         tag, op, k, ctrl, tstate, halted, exp_q[k], k);
            end
            if ((exp_q[k] & W_FI) != 16'h0000) {mc, mz} = {c, z};
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b1; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
        mc = 1'b0; mz = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (ctrl !== 16'h0000 || tstate !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ctrl=%h tstate=%0d halted=%b, required 0000/0/0", ctrl, tstate, halted);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctrl !== 16'h0000 || tstate !== 3'd0) begin
            errors++;
            $display("FAIL reset_cycle: ctrl=%h tstate=%0d, required 0000/0", ctrl, tstate);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ldi_out;
        run_instr("ldi", 4'h5, 1'b0, 1'b0);
        run_instr("out", 4'hE, 1'b0, 1'b0);
    endtask

    task automatic test_add;
        run_instr("add", 4'h2, 1'($urandom), 1'($urandom));
        run_instr("nop_after_add", 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_cond_jump;
        run_instr("sub_flags", 4'h3, 1'b1, 1'b1);
        run_instr("jz_taken", 4'h8, 1'b0, 1'b0);
        run_instr("jc_taken", 4'h7, 1'b0, 1'b0);
        run_instr("add_clear", 4'h2, 1'b0, 1'b0);
        run_instr("jc_not_taken", 4'h7, 1'b1, 1'b1);
        run_instr("jz_not_taken", 4'h8, 1'b1, 1'b1);
        run_instr("lda", 4'h1, 1'b0, 1'b0);
    endtask

    task automatic test_pause;
        build_expected(4'h2);
        for (int k = 0; k < exp_q.size(); k++) begin
            opcode = 4'h2; carry = 1'b0; zero = 1'b0;
            if (k >= 2) run = 1'b0;
            #1;
            checks++;
            if (ctrl !== exp_q[k] || tstate !== 3'(k)) begin
                errors++;
                $display("FAIL pause_add step %0d: ctrl=%h tstate=%0d, required ctrl=%h tstate=%0d",
                         k, ctrl, tstate, exp_q[k], k);
            end
            if ((exp_q[k] & W_FI) != 16'h0000) {mc, mz} = 2'b00;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            opcode = 4'($urandom);
            if (i == 9) run = 1'b1;
            #1;
            checks++;
            if (ctrl !== 16'h0000 || tstate !== 3'd0) begin
                errors++;
                $display("FAIL paused cycle %0d: ctrl=%h tstate=%0d, required 0000/0", i, ctrl, tstate);
            end
            @(posedge clk); #1;
        end
        run_instr("resume", 4'h6, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF) op = 4'h0;
            run_instr("random", op, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_sta;
        build_expected(4'h4);
        for (int k = 0; k < 4; k++) begin
            opcode = 4'h4;
            #1;
            checks++;
            if (ctrl !== exp_q[k] || tstate !== 3'(k)) begin
                errors++;
                $display("FAIL sta_pre_reset step %0d: ctrl=%h tstate=%0d, required ctrl=%h tstate=%0d",
                         k, ctrl, tstate, exp_q[k], k);
            end
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== 16'h0000 || tstate !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ctrl=%h tstate=%0d halted=%b, required 0000/0/0", ctrl, tstate, halted);
        end
        @(posedge clk); #1;
        checks++;
        if (ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL no_ri_pulse: ctrl=%h, required 0000", ctrl);
        end
        rst_n = 1'b1; mc = 1'b0; mz = 1'b0;
        #1;
        checks++;
        if (ctrl !== 16'h0000 || tstate !== 3'd0) begin
            errors++;
            $display("FAIL reset_release_cycle: ctrl=%h tstate=%0d, required 0000/0", ctrl, tstate);
        end
        @(posedge clk); #1;
        run_instr("fetch_after_reset", 4'h5, 1'b0, 1'b0);
    endtask

    task automatic test_hlt;
        run_instr("hlt", 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom);
            opcode = 4'($urandom);
            #1;
            checks++;
            if (ctrl !== W_HLT || halted !== 1'b1 || tstate !== 3'd2) begin
                errors++;
                $display("FAIL halted cycle %0d: ctrl=%h halted=%b tstate=%0d, required 8000/1/2",
                         i, ctrl, halted, tstate);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_ldi_out();
        test_add();
        test_cond_jump();
        test_pause();
        test_random();
        test_reset_mid_sta();
        test_hlt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
